// File: rtl/detect_stream_ctrl_pkg.sv
// Shared types for the detector stream controller: FSM state encoding and
// the deepest detector flag latency the valid delay line supports.
package detect_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      DRAIN,
      DONE
   } state_t;

   localparam int FLAG_LAT_MAX = 3;

endpackage

// File: rtl/detect_stream_ctrl_if.sv
// Host + detector signal bundle for detect_stream_ctrl. The controller takes
// the slave view; the host/detector side takes the master view.
interface detect_stream_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
);
   logic             start;
   logic [WIDTH-1:0] data;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] hit_cnt;
   logic             det_rst;
   logic             det_din;
   logic             det_flag;

   modport master (
      output start, data, det_flag,
      input  busy, done, hit_cnt, det_rst, det_din
   );

   modport slave (
      input  start, data, det_flag,
      output busy, done, hit_cnt, det_rst, det_din
   );
endinterface

// File: rtl/detect_stream_ctrl_piso_shift.sv
// Parallel-in serial-out shifter, LSB first. Load takes priority over shift.
module piso_shift #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_sout
);
   logic [WIDTH-1:0] r_shreg;

   always_ff @(posedge i_clk) begin
      if (i_rst)        r_shreg <= '0;
      else if (i_load)  r_shreg <= i_data;
      else if (i_shift) r_shreg <= r_shreg >> 1;
   end

   assign o_sout = r_shreg[0];
endmodule

// File: rtl/detect_stream_ctrl.sv
// Streams a parallel word into a serial sequence detector and counts its
// flag hits over exactly the WIDTH-bit window, offset by the flag latency.
module detect_stream_ctrl
   import detect_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CNT_W    = 6,
   parameter int FLAG_LAT = 1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   detect_stream_ctrl_if.slave bus
);
   localparam int LAT  = (FLAG_LAT > FLAG_LAT_MAX) ? FLAG_LAT_MAX : FLAG_LAT;
   localparam int BC_W = (WIDTH > 4) ? $clog2(WIDTH) : 2;

   state_t           r_state, w_next;
   logic             w_load, w_in_shift, w_vld_dly, w_sout;
   logic [BC_W-1:0]  r_bit_cnt;
   logic [CNT_W-1:0] r_hit_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         IDLE:  if (bus.start) begin
                   w_next = CLEAR;
                   w_load = 1'b1;
                end
         CLEAR: w_next = SHIFT;
         SHIFT: if (r_bit_cnt == BC_W'(WIDTH - 1)) w_next = (LAT == 0) ? DONE : DRAIN;
         DRAIN: if (r_bit_cnt == BC_W'(LAT - 1)) w_next = DONE;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_in_shift  = (r_state == SHIFT);
   assign bus.busy    = (r_state == CLEAR) || (r_state == SHIFT) || (r_state == DRAIN);
   assign bus.done    = (r_state == DONE);
   assign bus.det_rst = i_rst || (r_state == CLEAR);
   assign bus.det_din = w_in_shift && w_sout;
   assign bus.hit_cnt = r_hit_cnt;

   piso_shift #(.WIDTH(WIDTH)) u_piso (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_shift (w_in_shift),
      .i_data  (bus.data),
      .o_sout  (w_sout)
   );

   // One counter serves both the SHIFT bit index and the DRAIN length.
   always_ff @(posedge i_clk) begin
      if (i_rst || (w_next != r_state)) r_bit_cnt <= '0;
      else if (w_in_shift || (r_state == DRAIN)) r_bit_cnt <= r_bit_cnt + BC_W'(1);
   end

   // Bit-valid delayed to line up with the detector's flag for that bit.
   generate
      if (LAT == 0) begin : g_nolat
         assign w_vld_dly = w_in_shift;
      end else begin : g_lat
         logic [LAT-1:0] r_vld_pipe;
         always_ff @(posedge i_clk) begin
            if (i_rst) r_vld_pipe <= '0;
            else begin
               r_vld_pipe[0] <= w_in_shift;
               for (int i = 1; i < LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
         end
         assign w_vld_dly = r_vld_pipe[LAT-1];
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst || w_load) r_hit_cnt <= '0;
      else if (w_vld_dly && bus.det_flag && (r_hit_cnt != '1))
         r_hit_cnt <= r_hit_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_detect_stream_ctrl.sv
// Scoreboard bench: three controllers (Moore, Mealy, narrow counter) each
// driving a stub detector; a negedge monitor checks every done pulse.
module tb_detect_stream_ctrl;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         rst_v[3];
   logic         start_v[3];
   logic [W-1:0] data_v[3];
   logic         glitch;

   detect_stream_ctrl_if #(.WIDTH(W), .CNT_W(6)) ifA ();
   detect_stream_ctrl_if #(.WIDTH(W), .CNT_W(6)) ifB ();
   detect_stream_ctrl_if #(.WIDTH(W), .CNT_W(4)) ifC ();

   assign ifA.start = start_v[0];  assign ifA.data = data_v[0];
   assign ifB.start = start_v[1];  assign ifB.data = data_v[1];
   assign ifC.start = start_v[2];  assign ifC.data = data_v[2];

   // Moore stubs register din, Mealy stub passes it straight through.
   logic stubA, stubC;
   always_ff @(posedge clk) stubA <= ifA.det_rst ? 1'b0 : ifA.det_din;
   always_ff @(posedge clk) stubC <= ifC.det_rst ? 1'b0 : ifC.det_din;
   assign ifA.det_flag = stubA | (glitch & (ifA.done | (ifA.det_rst & ~rst_v[0])));
   assign ifB.det_flag = ifB.det_din;
   assign ifC.det_flag = stubC;

   detect_stream_ctrl #(.WIDTH(W), .CNT_W(6), .FLAG_LAT(1)) dutA (.i_clk(clk), .i_rst(rst_v[0]), .bus(ifA));
   detect_stream_ctrl #(.WIDTH(W), .CNT_W(6), .FLAG_LAT(0)) dutB (.i_clk(clk), .i_rst(rst_v[1]), .bus(ifB));
   detect_stream_ctrl #(.WIDTH(W), .CNT_W(4), .FLAG_LAT(1)) dutC (.i_clk(clk), .i_rst(rst_v[2]), .bus(ifC));

   logic       busy_o[3], done_o[3], drst_o[3], din_o[3];
   logic [5:0] cnt_o[3];
   assign busy_o[0] = ifA.busy;    assign busy_o[1] = ifB.busy;    assign busy_o[2] = ifC.busy;
   assign done_o[0] = ifA.done;    assign done_o[1] = ifB.done;    assign done_o[2] = ifC.done;
   assign drst_o[0] = ifA.det_rst; assign drst_o[1] = ifB.det_rst; assign drst_o[2] = ifC.det_rst;
   assign din_o[0]  = ifA.det_din; assign din_o[1]  = ifB.det_din; assign din_o[2]  = ifC.det_din;
   assign cnt_o[0]  = ifA.hit_cnt; assign cnt_o[1]  = ifB.hit_cnt; assign cnt_o[2]  = {2'b00, ifC.hit_cnt};

   typedef struct {
      logic [31:0] word;
      int          cnt;
      longint      done_cyc;
      int          blen;
   } exp_t;

   exp_t sb[3][$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic int lat_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Monitor: rebuild the serial word from det_din and check each done.
   int          blen[3] = '{0, 0, 0};
   int          idx[3]  = '{W, W, W};
   logic [31:0] word[3];
   exp_t        e;
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (drst_o[i] && !rst_v[i]) idx[i] = 0;
         else if (busy_o[i] && idx[i] < W) begin
            word[i][idx[i]] = din_o[i];
            idx[i]++;
         end
         if (done_o[i]) begin
            if (sb[i].size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done%0d: got done=1 expected no done (cyc %0d)", i, cyc);
            end else begin
               e = sb[i].pop_front();
               chk($sformatf("hit_cnt%0d", i), 64'(cnt_o[i]), 64'(e.cnt));
               chk($sformatf("done_cyc%0d", i), 64'(cyc), 64'(e.done_cyc));
               chk($sformatf("busy_len%0d", i), 64'(blen[i]), 64'(e.blen));
               chk($sformatf("serial_word%0d", i), 64'(word[i]), 64'(e.word));
            end
            blen[i] = 0;
         end else if (busy_o[i]) blen[i]++;
         else blen[i] = 0;
      end
   end

   // Call at a negedge; the next posedge accepts. DONE lands W+LAT+1 edges
   // after the accepting edge; busy covers CLEAR + W SHIFT + LAT DRAIN.
   task automatic go(input int i, input logic [31:0] d, input int cnt);
      start_v[i] = 1'b1;
      data_v[i]  = d;
      sb[i].push_back('{word: d, cnt: cnt, done_cyc: cyc + W + lat_of(i) + 2,
                        blen: W + lat_of(i) + 1});
   endtask

   task automatic drop_starts();
      @(negedge clk);
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      glitch = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rst_v[i] = 1'b1; start_v[i] = 1'b0; data_v[i] = '0;
      end
      start_v[0] = 1'b1;  // start during reset must lose to rst
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_busy%0d", i), 64'(busy_o[i]), 64'd0);
         chk($sformatf("rst_done%0d", i), 64'(done_o[i]), 64'd0);
         chk($sformatf("rst_hit%0d", i),  64'(cnt_o[i]),  64'd0);
         chk($sformatf("rst_detrst%0d", i), 64'(drst_o[i]), 64'd1);
         chk($sformatf("rst_detdin%0d", i), 64'(din_o[i]),  64'd0);
      end
      start_v[0] = 1'b0;
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
      @(negedge clk);
      chk("idle_detrst0", 64'(drst_o[0]), 64'd0);

      // popcount(0x6AA36155) = 15
      go(0, 32'h6AA36155, 15); go(1, 32'h6AA36155, 15); go(2, 32'h6AA36155, 15);
      drop_starts();
      repeat (40) @(negedge clk);

      // MSB only: last flag arrives in DRAIN; all-ones saturates a 4-bit count
      go(0, 32'h80000000, 1); go(1, 32'h80000000, 1); go(2, 32'hFFFFFFFF, 15);
      drop_starts();
      repeat (40) @(negedge clk);

      // flag forced high in CLEAR and DONE must not add hits
      glitch = 1'b1;
      go(0, 32'h00000001, 1); go(1, 32'hFFFFFFFF, 32); go(2, 32'h00000001, 1);
      drop_starts();
      repeat (40) @(negedge clk);
      glitch = 1'b0;

      // re-pulse during SHIFT is ignored
      go(0, 32'h6AA36155, 15);
      drop_starts();
      repeat (10) @(negedge clk);
      start_v[0] = 1'b1; data_v[0] = 32'hFFFFFFFF;
      @(negedge clk);
      start_v[0] = 1'b0;
      begin
         int n = 0;
         while (!done_o[0] && n < 60) begin
            @(negedge clk);
            n++;
         end
         chk("done_seen_run4", 64'(done_o[0]), 64'd1);
      end
      // start held in the DONE cycle is ignored
      start_v[0] = 1'b1; data_v[0] = 32'h0;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("start_in_done_busy", 64'(busy_o[0]), 64'd0);
      chk("hit_hold", 64'(cnt_o[0]), 64'd15);
      repeat (5) @(negedge clk);

      // reset during SHIFT bit 10 aborts with no done
      go(0, 32'h6AA36155, 15);
      drop_starts();
      repeat (11) @(negedge clk);
      rst_v[0] = 1'b1;
      sb[0].delete();
      @(negedge clk);
      chk("abort_busy", 64'(busy_o[0]), 64'd0);
      chk("abort_hit", 64'(cnt_o[0]), 64'd0);
      chk("abort_detrst", 64'(drst_o[0]), 64'd1);
      chk("abort_done", 64'(done_o[0]), 64'd0);
      chk("abort_detdin", 64'(din_o[0]), 64'd0);
      rst_v[0] = 1'b0;
      @(negedge clk);
      chk("abort_detrst_rel", 64'(drst_o[0]), 64'd0);
      repeat (45) @(negedge clk);

      go(0, 32'h6AA36155, 15);
      drop_starts();
      repeat (40) @(negedge clk);

      for (int i = 0; i < 3; i++) chk($sformatf("sb_empty%0d", i), 64'(sb[i].size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
